// File: rtl/dma_pkg.sv
// Shared types and constants for the byte-wide bus DMA engine.
// Address width matches the CPU-side memory bus.
package dma_pkg;

  localparam int ADDR_W = 24;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] addr_inc(
    input logic [ADDR_W-1:0] a
  );
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/bus_dma_if.sv
// CPU-side memory bus as seen by an initiator (master)
// and the memory/arbiter side (slave).
interface bus_dma_if;
  import dma_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [7:0]        data_out;
  logic [7:0]        data_in;
  logic              bus_enable;
  logic              write_enable;
  logic              bus_halt;

  modport master (
    output address,
    output data_out,
    output bus_enable,
    output write_enable,
    input  data_in,
    input  bus_halt
  );

  modport slave (
    input  address,
    input  data_out,
    input  bus_enable,
    input  write_enable,
    output data_in,
    output bus_halt
  );

endinterface

// File: rtl/bus_dma.sv
// Byte-wide block copy / block fill bus initiator.
// Every output is a flop; bus_halt freezes the access in flight.
module bus_dma
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter int READ_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [ADDR_W-1:0]    src_addr,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic [7:0]           fill_value,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [LEN_WIDTH-1:0] bytes_left,
  bus_dma_if.master            bus
);

  localparam int CW =
    (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(READ_WAIT);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE =
    LEN_WIDTH'(1);

  state_e state_q, state_d;

  logic [ADDR_W-1:0]    src_q, src_d;
  logic [ADDR_W-1:0]    dst_q, dst_d;
  logic                 mode_q, mode_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] bytes_left_q, bytes_left_d;
  logic [ADDR_W-1:0]    address_q, address_d;
  logic [7:0]           data_out_q, data_out_d;
  logic                 bus_enable_q, bus_enable_d;
  logic                 write_enable_q, write_enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    mode_d         = mode_q;
    cnt_d          = cnt_q;
    bytes_left_d   = bytes_left_q;
    address_d      = address_q;
    data_out_d     = data_out_q;
    bus_enable_d   = bus_enable_q;
    write_enable_d = write_enable_q;
    done_d         = 1'b0;
    aborted_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bus_enable_d   = 1'b0;
        write_enable_d = 1'b0;
        if (start) begin
          src_d        = src_addr;
          dst_d        = dst_addr;
          mode_d       = mode;
          bytes_left_d = length;
          if (length == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (mode == MODE_FILL) begin
            state_d        = ST_WRITE;
            address_d      = dst_addr;
            data_out_d     = fill_value;
            bus_enable_d   = 1'b1;
            write_enable_d = 1'b1;
          end else begin
            state_d        = ST_READ;
            address_d      = src_addr;
            bus_enable_d   = 1'b1;
            write_enable_d = 1'b0;
            cnt_d          = WAIT_INIT;
          end
        end
      end

      ST_READ: begin
        if (abort) begin
          state_d        = ST_IDLE;
          aborted_d      = 1'b1;
          bus_enable_d   = 1'b0;
          write_enable_d = 1'b0;
        end else if (!bus.bus_halt) begin
          // a halted cycle also freezes the wait count
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            data_out_d     = bus.data_in;
            src_d          = addr_inc(src_q);
            state_d        = ST_WRITE;
            address_d      = dst_q;
            write_enable_d = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (!bus.bus_halt) begin
          dst_d        = addr_inc(dst_q);
          bytes_left_d = bytes_left_q - LEN_ONE;
        end
        // a write landing on the abort edge still counts
        if (abort) begin
          state_d        = ST_IDLE;
          aborted_d      = 1'b1;
          bus_enable_d   = 1'b0;
          write_enable_d = 1'b0;
        end else if (!bus.bus_halt) begin
          if (bytes_left_q == LEN_ONE) begin
            state_d        = ST_DONE;
            done_d         = 1'b1;
            bus_enable_d   = 1'b0;
            write_enable_d = 1'b0;
          end else if (mode_q == MODE_COPY) begin
            state_d        = ST_READ;
            address_d      = src_q;
            write_enable_d = 1'b0;
            cnt_d          = WAIT_INIT;
          end else begin
            address_d = dst_d;
          end
        end
      end

      ST_DONE: begin
        state_d        = ST_IDLE;
        bus_enable_d   = 1'b0;
        write_enable_d = 1'b0;
      end

      default: begin
        state_d        = ST_IDLE;
        bus_enable_d   = 1'b0;
        write_enable_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      mode_q         <= MODE_COPY;
      cnt_q          <= '0;
      bytes_left_q   <= '0;
      address_q      <= '0;
      data_out_q     <= '0;
      bus_enable_q   <= 1'b0;
      write_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      mode_q         <= mode_d;
      cnt_q          <= cnt_d;
      bytes_left_q   <= bytes_left_d;
      address_q      <= address_d;
      data_out_q     <= data_out_d;
      bus_enable_q   <= bus_enable_d;
      write_enable_q <= write_enable_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign aborted          = aborted_q;
  assign bytes_left       = bytes_left_q;
  assign bus.address      = address_q;
  assign bus.data_out     = data_out_q;
  assign bus.bus_enable   = bus_enable_q;
  assign bus.write_enable = write_enable_q;

endmodule

// File: tb/tb_bus_dma.sv
// Randomized bench for bus_dma against a byte-level
// memory model and a per-transfer timing rule.
module tb_bus_dma;
  import dma_pkg::*;

  localparam int LW = 16;
  localparam int RW = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [23:0]   src_addr;
  logic [23:0]   dst_addr;
  logic [LW-1:0] length;
  logic [7:0]    fill_value;
  logic          abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [LW-1:0] bytes_left;

  bus_dma_if bus ();

  bus_dma #(
    .LEN_WIDTH (LW),
    .READ_WAIT (RW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_value (fill_value),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .bytes_left (bytes_left),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [logic [23:0]];
  logic [31:0] wr_q[$];
  logic [23:0] rd_q[$];

  function automatic logic [7:0] rd(input logic [23:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // memory slave: read data follows the address, writes land on the edge
  always @(negedge clk) bus.data_in = rd(bus.address);

  always @(posedge clk) begin
    if (bus.bus_enable && bus.write_enable && !bus.bus_halt) begin
      mem[bus.address] = bus.data_out;
      wr_q.push_back({bus.address, bus.data_out});
    end
  end

  always @(negedge clk) begin
    if (bus.bus_enable && !bus.write_enable &&
        (rd_q.size() == 0 || rd_q[$] != bus.address))
      rd_q.push_back(bus.address);
  end

  task automatic launch(input logic m, input logic [23:0] s,
                        input logic [23:0] d, input logic [LW-1:0] len,
                        input logic [7:0] fv);
    wr_q.delete();
    rd_q.delete();
    mode = m; src_addr = s; dst_addr = d;
    length = len; fill_value = fv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_xfer(input int hfirst, input int hpct, input int budget,
                          output int cyc, output int halts, output int wec);
    logic ph, pbe, pwe;
    logic [23:0] pa;
    logic [7:0] pd;
    cyc = 0; halts = 0; wec = 0;
    while (done !== 1'b1 && cyc < budget) begin
      ph = (cyc < hfirst) ||
           (hpct > 0 && int'($urandom_range(0, 99)) < hpct);
      bus.bus_halt = ph;
      pa = bus.address; pd = bus.data_out;
      pbe = bus.bus_enable; pwe = bus.write_enable;
      if (pwe) wec++;
      @(negedge clk);
      cyc++;
      if (ph && pbe) begin
        halts++;
        vectors++;
        if ({bus.address, bus.data_out, bus.write_enable} !== {pa, pd, pwe}) begin
          miscompares++;
          $display("FAIL halt_hold: got %h/%h/%b required %h/%h/%b",
                   bus.address, bus.data_out, bus.write_enable, pa, pd, pwe);
        end
      end
    end
    bus.bus_halt = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL xfer_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, aborted, bytes_left, bus.address, bus.data_out,
         bus.bus_enable, bus.write_enable} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b ab=%b bl=%h a=%h d=%h be=%b we=%b required all 0",
               busy, done, aborted, bytes_left, bus.address, bus.data_out,
               bus.bus_enable, bus.write_enable);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_copy(input logic [23:0] s, input logic [23:0] d,
                           input int len, input int hfirst, input int hpct);
    logic [7:0] src_b[$];
    logic [31:0] got, exp;
    int cyc, halts, wec;
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      mem[s + 24'(i)] = b;
      src_b.push_back(b);
    end
    launch(MODE_COPY, s, d, LW'(len), 8'h00);
    run_xfer(hfirst, hpct, 4000, cyc, halts, wec);
    vectors++;
    if (cyc !== len * (RW + 2) + halts) begin
      miscompares++;
      $display("FAIL copy_cycles: got %0d required %0d", cyc, len * (RW + 2) + halts);
    end
    if (hpct == 0) begin
      vectors++;
      if (halts !== hfirst) begin
        miscompares++;
        $display("FAIL copy_halts: got %0d required %0d", halts, hfirst);
      end
    end
    vectors++;
    if (wr_q.size() !== len) begin
      miscompares++;
      $display("FAIL copy_wcount: got %0d required %0d", wr_q.size(), len);
    end
    for (int i = 0; i < len; i++) begin
      got = (i < wr_q.size()) ? wr_q[i] : 32'hxxxxxxxx;
      exp = {d + 24'(i), src_b[i]};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL copy_write[%0d]: got %h required %h", i, got, exp);
      end
    end
    vectors++;
    if (bytes_left !== '0) begin
      miscompares++;
      $display("FAIL copy_left: got %0d required 0", bytes_left);
    end
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL copy_idle: busy/done got %b%b required 00", busy, done);
    end
  endtask

  task automatic test_fill(input logic [23:0] d, input logic [7:0] fv,
                           input int len, input int hpct);
    logic [31:0] got, exp;
    int cyc, halts, wec;
    launch(MODE_FILL, 24'h0, d, LW'(len), fv);
    run_xfer(0, hpct, 4000, cyc, halts, wec);
    vectors++;
    if (cyc !== len + halts) begin
      miscompares++;
      $display("FAIL fill_cycles: got %0d required %0d", cyc, len + halts);
    end
    vectors++;
    if (wec !== len + halts) begin
      miscompares++;
      $display("FAIL fill_we_cycles: got %0d required %0d", wec, len + halts);
    end
    vectors++;
    if (wr_q.size() !== len) begin
      miscompares++;
      $display("FAIL fill_wcount: got %0d required %0d", wr_q.size(), len);
    end
    for (int i = 0; i < len; i++) begin
      got = (i < wr_q.size()) ? wr_q[i] : 32'hxxxxxxxx;
      exp = {d + 24'(i), fv};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL fill_write[%0d]: got %h required %h", i, got, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_zero_len;
    launch(MODE_COPY, 24'h000100, 24'h000200, '0, 8'h00);
    vectors++;
    if ({done, busy, bus.bus_enable} !== 3'b110) begin
      miscompares++;
      $display("FAIL zero_done: done/busy/be got %b%b%b required 110",
               done, busy, bus.bus_enable);
    end
    @(negedge clk);
    vectors++;
    if ({done, busy, bus.bus_enable} !== 3'b000 || wr_q.size() != 0) begin
      miscompares++;
      $display("FAIL zero_idle: done/busy/be got %b%b%b writes %0d required 000 and 0",
               done, busy, bus.bus_enable, wr_q.size());
    end
  endtask

  task automatic test_abort;
    int n, cyc, halts, wec;
    for (int i = 0; i < 8; i++) mem[24'h003000 + 24'(i)] = 8'($urandom);
    launch(MODE_COPY, 24'h003000, 24'h004000, LW'(8), 8'h00);
    n = 0;
    while (!(bus.write_enable && wr_q.size() == 1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 60) begin
      miscompares++;
      $display("FAIL abort_reach: second write not seen in %0d cycles", n);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if ({aborted, done, bus.bus_enable, bus.write_enable, busy} !== 5'b10000) begin
      miscompares++;
      $display("FAIL abort_flags: ab/done/be/we/busy got %b%b%b%b%b required 10000",
               aborted, done, bus.bus_enable, bus.write_enable, busy);
    end
    vectors++;
    if (bytes_left !== LW'(6) || wr_q.size() != 2) begin
      miscompares++;
      $display("FAIL abort_left: got %0d (writes %0d) required 6 (writes 2)",
               bytes_left, wr_q.size());
    end
    @(negedge clk);
    vectors++;
    if ({aborted, busy} !== 2'b00 || bytes_left !== LW'(6)) begin
      miscompares++;
      $display("FAIL abort_after: ab/busy got %b%b left %0d required 00 left 6",
               aborted, busy, bytes_left);
    end
    abort = 1'b1;
    launch(MODE_FILL, 24'h0, 24'h004800, LW'(2), 8'h3C);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_beats_abort: busy got %b required 1", busy);
    end
    run_xfer(0, 0, 100, cyc, halts, wec);
    vectors++;
    if (cyc !== 2 || wr_q.size() != 2 ||
        (wr_q.size() == 2 && wr_q[1] !== {24'h004801, 8'h3C})) begin
      miscompares++;
      $display("FAIL restart_fill: cycles %0d writes %0d required 2 and 2", cyc, wr_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] b[3];
    int cyc, halts, wec;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom);
      mem[24'h005000 + 24'(i)] = b[i];
    end
    launch(MODE_COPY, 24'h005000, 24'h006000, LW'(3), 8'h00);
    mode = MODE_FILL; dst_addr = 24'h007000; length = LW'(5);
    fill_value = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_xfer(0, 0, 100, cyc, halts, wec);
    vectors++;
    if (cyc !== 3 * (RW + 2) - 1) begin
      miscompares++;
      $display("FAIL busy_start_cycles: got %0d required %0d", cyc, 3 * (RW + 2) - 1);
    end
    vectors++;
    if (wr_q.size() != 3 ||
        (wr_q.size() == 3 && wr_q[2] !== {24'h006002, b[2]})) begin
      miscompares++;
      $display("FAIL busy_start_data: writes %0d required 3 copy bytes", wr_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b0, b1;
    int cyc, halts, wec;
    launch(MODE_COPY, 24'h008000, 24'h009000, LW'(8), 8'h00);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, aborted, bytes_left, bus.address, bus.data_out,
         bus.bus_enable, bus.write_enable} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b bl=%h a=%h d=%h be=%b we=%b required all 0",
               busy, bytes_left, bus.address, bus.data_out,
               bus.bus_enable, bus.write_enable);
    end
    reset = 1'b0;
    @(negedge clk);
    b0 = 8'($urandom); b1 = 8'($urandom);
    mem[24'hFFFFFF] = b0;
    mem[24'h000000] = b1;
    launch(MODE_COPY, 24'hFFFFFF, 24'h123456, LW'(2), 8'h00);
    run_xfer(0, 0, 100, cyc, halts, wec);
    vectors++;
    if (rd_q.size() != 2 ||
        (rd_q.size() == 2 && {rd_q[0], rd_q[1]} !== {24'hFFFFFF, 24'h000000})) begin
      miscompares++;
      $display("FAIL wrap_reads: %0d reads, first %h, required FFFFFF then 000000",
               rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 24'hx);
    end
    vectors++;
    if (wr_q.size() != 2 ||
        (wr_q.size() == 2 && {wr_q[0], wr_q[1]} !==
         {24'h123456, b0, 24'h123457, b1})) begin
      miscompares++;
      $display("FAIL wrap_writes: %0d writes required 2 with %h %h", wr_q.size(), b0, b1);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [23:0] s, d;
    reset = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    bus.bus_halt = 1'b0;
    test_reset;
    test_copy(24'h000100, 24'h000200, 4, 0, 0);
    test_fill(24'h00FFFF, 8'hA5, 3, 0);
    test_copy(24'h000300, 24'h000400, 2, 5, 0);
    test_zero_len;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    repeat (6) begin
      s = 24'($urandom);
      d = s + 24'h008000 + 24'($urandom_range(0, 28672));
      test_copy(s, d, int'($urandom_range(1, 12)), 0, 25);
    end
    repeat (4) begin
      test_fill(24'($urandom), 8'($urandom), int'($urandom_range(1, 12)), 25);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
